// File: rtl/multiplier_pipe.sv
// multiplier_pipe: unsigned WIDTH x WIDTH multiplier with registered inputs and outputs.
// Partial products come from an AND array. They are reduced row-wise with 4:2
// compressors, then 3:2 (full-adder) stages until two rows remain. A ripple-carry
// adder then produces the product. A valid flag travels alongside the data.
//
// Optional build macro:
//   MULTIPLIER_PIPE_EN - registers the two reduced rows before the final adder
//                        (latency 3 instead of 2).
//
// Ports:
//   clk       - rising-edge clock
//   rst       - synchronous active-high reset
//   in_valid  - A/B are captured this cycle
//   A, B      - WIDTH-bit unsigned operands
//   P         - 2*WIDTH-bit registered product
//   out_valid - one-cycle pulse when P holds a new product
module multiplier_pipe #(
    parameter int unsigned WIDTH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic [2*WIDTH-1:0]   P,
    output logic                 out_valid
);

    localparam int unsigned PW = 2 * WIDTH;

    typedef logic [PW-1:0] row_t;

    // 4:2 compressor applied bit-wise across a row.
    // cout chains into the next column. The carry row is weighted one column up.
    // Carries beyond PW-1 are dropped because the true product always fits.
    function automatic logic [2*PW-1:0] compress42(input row_t a, input row_t b,
                                                   input row_t c, input row_t d);
        row_t s;
        row_t cy;
        logic cin;
        logic cout;
        logic s1;
        s   = '0;
        cy  = '0;
        cin = 1'b0;
        for (int unsigned k = 0; k < PW; k++) begin
            s1   = a[k] ^ b[k] ^ c[k];
            cout = (a[k] & b[k]) | (a[k] & c[k]) | (b[k] & c[k]);
            s[k] = s1 ^ d[k] ^ cin;
            if (k + 1 < PW) begin
                cy[k+1] = (s1 & d[k]) | (s1 & cin) | (d[k] & cin);
            end
            cin = cout;
        end
        return {cy, s};
    endfunction

    // 3:2 carry-save stage made of full adders, one per column.
    function automatic logic [2*PW-1:0] compress32(input row_t a, input row_t b,
                                                   input row_t c);
        row_t s;
        row_t cy;
        s  = a ^ b ^ c;
        cy = ((a & b) | (a & c) | (b & c)) << 1;
        return {cy, s};
    endfunction

    // Final carry-propagate adder.
    function automatic row_t add_ripple(input row_t x, input row_t y);
        row_t s;
        logic c;
        s = '0;
        c = 1'b0;
        for (int unsigned k = 0; k < PW; k++) begin
            s[k] = x[k] ^ y[k] ^ c;
            c    = (x[k] & y[k]) | (x[k] & c) | (y[k] & c);
        end
        return s;
    endfunction

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             v0_q;
    row_t             row0_c;
    row_t             row1_c;
    row_t             add_a_c;
    row_t             add_b_c;
    logic             add_v_c;
    row_t             sum_c;

    // Input register. The operands hold while no new pair is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q  <= '0;
            b_q  <= '0;
            v0_q <= 1'b0;
        end else begin
            v0_q <= in_valid;
            if (in_valid) begin
                a_q <= A;
                b_q <= B;
            end
        end
    end

    // Partial-product array reduced to two rows.
    always_comb begin : reduce_tree
        row_t        rows [WIDTH];
        row_t        nxt  [WIDTH];
        int unsigned n;
        int unsigned m;
        int unsigned base;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            rows[i] = row_t'(a_q & {WIDTH{b_q[i]}}) << i;
            nxt[i]  = '0;
        end
        n    = WIDTH;
        m    = 0;
        base = 0;
        // 4:2 levels while at least four rows remain.
        for (int unsigned lvl = 0; lvl < WIDTH; lvl++) begin
            if (n >= 4) begin
                for (int unsigned i = 0; i < WIDTH; i++) nxt[i] = '0;
                m    = 0;
                base = (n / 4) * 4;
                for (int unsigned g = 0; g + 4 <= WIDTH; g += 4) begin
                    if (g + 4 <= n) begin
                        {nxt[m+1], nxt[m]} = compress42(rows[g], rows[g+1],
                                                        rows[g+2], rows[g+3]);
                        m += 2;
                    end
                end
                for (int unsigned i = 0; i < WIDTH; i++) begin
                    if (i >= base && i < n) begin
                        nxt[m] = rows[i];
                        m += 1;
                    end
                end
                rows = nxt;
                n    = m;
            end
        end
        // Full-adder levels until two rows remain.
        for (int unsigned lvl = 0; lvl < WIDTH; lvl++) begin
            if (n > 2) begin
                for (int unsigned i = 0; i < WIDTH; i++) nxt[i] = '0;
                m    = 0;
                base = (n / 3) * 3;
                for (int unsigned g = 0; g + 3 <= WIDTH; g += 3) begin
                    if (g + 3 <= n) begin
                        {nxt[m+1], nxt[m]} = compress32(rows[g], rows[g+1], rows[g+2]);
                        m += 2;
                    end
                end
                for (int unsigned i = 0; i < WIDTH; i++) begin
                    if (i >= base && i < n) begin
                        nxt[m] = rows[i];
                        m += 1;
                    end
                end
                rows = nxt;
                n    = m;
            end
        end
        row0_c = rows[0];
        row1_c = rows[1];
    end

`ifdef MULTIPLIER_PIPE_EN
    row_t row0_q;
    row_t row1_q;
    logic v1_q;

    // Optional register between the reduction tree and the final adder.
    always_ff @(posedge clk) begin
        if (rst) begin
            row0_q <= '0;
            row1_q <= '0;
            v1_q   <= 1'b0;
        end else begin
            row0_q <= row0_c;
            row1_q <= row1_c;
            v1_q   <= v0_q;
        end
    end

    assign add_a_c = row0_q;
    assign add_b_c = row1_q;
    assign add_v_c = v1_q;
`else
    assign add_a_c = row0_c;
    assign add_b_c = row1_c;
    assign add_v_c = v0_q;
`endif

    assign sum_c = add_ripple(add_a_c, add_b_c);

    // Output register. P only changes when a valid product arrives.
    always_ff @(posedge clk) begin
        if (rst) begin
            P         <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= add_v_c;
            if (add_v_c) begin
                P <= sum_c;
            end
        end
    end

endmodule

// File: tb/tb_multiplier_pipe.sv
// Testbench for multiplier_pipe. It runs a WIDTH=2 and a WIDTH=8 instance side
// by side against a product/delay-queue reference model.
module tb_multiplier_pipe;

`ifdef MULTIPLIER_PIPE_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic        clk;
    logic        rst;
    logic        in_valid2;
    logic [1:0]  a2;
    logic [1:0]  b2;
    logic [3:0]  p2;
    logic        out_valid2;
    logic        in_valid8;
    logic [7:0]  a8;
    logic [7:0]  b8;
    logic [15:0] p8;
    logic        out_valid8;

    int vectors     = 0;
    int miscompares = 0;
    bit chk_en      = 0;

    multiplier_pipe #(.WIDTH(2)) u2 (
        .clk(clk), .rst(rst), .in_valid(in_valid2), .A(a2), .B(b2),
        .P(p2), .out_valid(out_valid2)
    );

    multiplier_pipe #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .A(a8), .B(b8),
        .P(p8), .out_valid(out_valid8)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: each accepted pair emerges LAT-1 edges after its
    // capture edge. The expected P holds the last product that emerged.
    bit          qv2 [$];
    int unsigned qp2 [$];
    bit          qv8 [$];
    int unsigned qp8 [$];
    bit          ev2 = 0;
    bit          ev8 = 0;
    int unsigned ep2 = 0;
    int unsigned ep8 = 0;

    always @(posedge clk) begin
        int unsigned p;
        if (rst) begin
            qv2.delete(); qp2.delete(); qv8.delete(); qp8.delete();
            ev2 = 0; ev8 = 0; ep2 = 0; ep8 = 0;
        end else begin
            ev2 = 0;
            if (qv2.size() == LAT - 1) begin
                ev2 = qv2.pop_front();
                p   = qp2.pop_front();
                if (ev2) ep2 = p;
            end
            qv2.push_back(in_valid2);
            qp2.push_back(int'(a2) * int'(b2));
            ev8 = 0;
            if (qv8.size() == LAT - 1) begin
                ev8 = qv8.pop_front();
                p   = qp8.pop_front();
                if (ev8) ep8 = p;
            end
            qv8.push_back(in_valid8);
            qp8.push_back(int'(a8) * int'(b8));
        end
    end

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("out_valid2", int'(out_valid2), int'(ev2));
            check("P2", int'(p2), ep2);
            check("out_valid8", int'(out_valid8), int'(ev8));
            check("P8", int'(p8), ep8);
        end
    end

    task automatic drive(input bit r, input bit v2, input int unsigned x2, input int unsigned y2,
                         input bit v8, input int unsigned x8, input int unsigned y8);
        rst       = r;
        in_valid2 = v2;
        a2        = 2'(x2);
        b2        = 2'(y2);
        in_valid8 = v8;
        a8        = 8'(x8);
        b8        = 8'(y8);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 0, 0, 1'b0, 0, 0);
    endtask

    // One isolated pair. Checks the latency and the literal product.
    task automatic single(input bit w8, input int unsigned x, input int unsigned y,
                          input int unsigned exp);
        int lat;
        bit got;
        if (w8) drive(1'b0, 1'b0, 0, 0, 1'b1, x, y);
        else    drive(1'b0, 1'b1, x, y, 1'b0, 0, 0);
        lat = 1;
        got = 0;
        for (int i = 0; i < 8 && !got; i++) begin
            idle();
            lat++;
            got = w8 ? out_valid8 : out_valid2;
        end
        if (!got) begin
            miscompares++;
            $display("FAIL single_timeout: no out_valid for %0d*%0d", x, y);
        end
        check(w8 ? "latency8" : "latency2", lat, LAT);
        check(w8 ? "single_P8" : "single_P2", w8 ? int'(p8) : int'(p2), exp);
    endtask

    initial begin
        int cnt;
        rst = 1'b1; in_valid2 = 1'b0; a2 = '0; b2 = '0;
        in_valid8 = 1'b0; a8 = '0; b8 = '0;

        // Reset held with in_valid asserted.
        drive(1'b1, 1'b1, 3, 3, 1'b1, 255, 255);
        chk_en = 1;
        for (int i = 0; i < 2; i++) begin
            check("rst_P2", int'(p2), 0);
            check("rst_ov2", int'(out_valid2), 0);
            drive(1'b1, 1'b1, 3, 3, 1'b1, 255, 255);
        end
        check("rst_P8", int'(p8), 0);

        // Single pairs.
        single(0, 1, 2, 2);
        single(0, 3, 2, 6);
        single(0, 3, 3, 9);
        single(0, 3, 1, 3);
        single(0, 1, 1, 1);
        single(0, 2, 1, 2);

        // Exhaustive back-to-back stream.
        cnt = 0;
        for (int x = 0; x < 4; x++) begin
            for (int y = 0; y < 4; y++) begin
                drive(1'b0, 1'b1, x, y, 1'b0, 0, 0);
                cnt += int'(out_valid2);
            end
        end
        for (int i = 0; i < LAT + 1; i++) begin
            idle();
            cnt += int'(out_valid2);
        end
        check("b2b_count", cnt, 16);

        // Gap handling.
        single(0, 3, 3, 9);
        for (int i = 0; i < 3; i++) begin
            idle();
            check("gap_P2", int'(p2), 9);
            check("gap_ov2", int'(out_valid2), 0);
        end
        single(0, 1, 3, 3);

        // Reset mid-flight.
        drive(1'b0, 1'b1, 3, 2, 1'b0, 0, 0);
        drive(1'b1, 1'b0, 0, 0, 1'b0, 0, 0);
        for (int i = 0; i < LAT + 1; i++) begin
            idle();
            check("midrst_ov2", int'(out_valid2), 0);
            check("midrst_P2", int'(p2), 0);
        end

        // Wide operands.
        single(1, 255, 255, 65025);
        single(1, 0, 200, 0);
        single(1, 200, 3, 600);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            drive(bit'($urandom_range(0, 39) == 0),
                  bit'($urandom_range(0, 1)), $urandom, $urandom,
                  bit'($urandom_range(0, 1)), $urandom, $urandom);
        end
        idle();
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
